// File: rtl/approx_adder_error_monitor.sv
// Streaming error statistics for approximate adders: recomputes the exact sum,
// forms the signed error and accumulates saturating count/bias/MSE/max counters.
module approx_adder_error_monitor #(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 32,
  parameter int ESUM_W = 40,
  parameter int SQ_W   = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH:0]    in_approx,
  input  logic              clear,
  output logic              stats_valid,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ESUM_W-1:0] err_sum,
  output logic [SQ_W-1:0]   sq_err_sum,
  output logic [WIDTH:0]    max_abs_err
);
  localparam int AW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * AW;
  localparam int SW = ((ESUM_W > EW) ? ESUM_W : EW) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, CLR} state_t;

  typedef struct packed {
    logic [EW-1:0] err;
    logic [AW-1:0] abs_err;
    logic [PW-1:0] sq;
  } s2_t;

  state_t state, state_nxt;
  logic [1:0]    vld_pipe;   // [0]=S1, [1]=S2
  logic [EW-1:0] s1_err;
  s2_t           s2;
  logic          accept;
  logic [AW-1:0] exact;
  logic [EW-1:0] err_c;
  logic [AW-1:0] abs_c;
  logic [SQ_W:0] sq_add;
  logic signed [SW-1:0] es_add, es_max, es_min;
  logic [ESUM_W-1:0]    es_sat;

  assign in_ready    = (state == RUN) && !rst;
  assign accept      = in_valid && in_ready;
  assign stats_valid = (state == RUN) && (vld_pipe == 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (clear) state_nxt = DRAIN;
      // S2 retires at the same edge CLR is entered, so only S1 must be empty
      DRAIN:   if (!vld_pipe[0]) state_nxt = CLR;
      CLR:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // S1: exact sum and signed error
  assign exact = {1'b0, in_a} + {1'b0, in_b};
  assign err_c = {1'b0, in_approx} - {1'b0, exact};

  // S2: magnitude fits in AW bits, so negate only the low bits
  assign abs_c = s1_err[EW-1] ? (~s1_err[AW-1:0] + AW'(1)) : s1_err[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= 2'b00;
    else     vld_pipe <= {vld_pipe[0], accept};
    if (accept) s1_err <= err_c;
    if (vld_pipe[0]) begin
      s2.err     <= s1_err;
      s2.abs_err <= abs_c;
      s2.sq      <= {{AW{1'b0}}, abs_c} * {{AW{1'b0}}, abs_c};
    end
  end

  // Saturating accumulators
  assign sq_add = {1'b0, sq_err_sum} + {{(SQ_W + 1 - PW){1'b0}}, s2.sq};
  assign es_max = {{(SW - ESUM_W + 1){1'b0}}, {(ESUM_W - 1){1'b1}}};
  assign es_min = ~es_max;
  assign es_add = {{(SW - ESUM_W){err_sum[ESUM_W-1]}}, err_sum}
                + {{(SW - EW){s2.err[EW-1]}}, s2.err};

  always_comb begin
    es_sat = es_add[ESUM_W-1:0];
    if (es_add > es_max)      es_sat = es_max[ESUM_W-1:0];
    else if (es_add < es_min) es_sat = es_min[ESUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || state == CLR) begin
      sample_count <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      sq_err_sum   <= '0;
      max_abs_err  <= '0;
    end else if (vld_pipe[1]) begin
      if (!(&sample_count)) sample_count <= sample_count + CNT_W'(1);
      if (s2.err != '0 && !(&err_count)) err_count <= err_count + CNT_W'(1);
      err_sum    <= es_sat;
      sq_err_sum <= sq_add[SQ_W] ? {SQ_W{1'b1}} : sq_add[SQ_W-1:0];
      if (s2.abs_err > max_abs_err) max_abs_err <= s2.abs_err;
    end
  end
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Randomised bench for approx_adder_error_monitor: an arithmetic model of the
// statistics is updated per accepted sample and compared once the pipe drains.
module tb_approx_adder_error_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid_s = 1'b0, clear = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [16:0] in_approx = '0;

  logic        in_ready, stats_valid;
  logic [31:0] sample_count, err_count;
  logic [39:0] err_sum;
  logic [55:0] sq_err_sum;
  logic [16:0] max_abs_err;

  logic        in_ready_s, stats_valid_s;
  logic [3:0]  sample_count_s, err_count_s;
  logic [7:0]  err_sum_s;
  logic [55:0] sq_err_sum_s;
  logic [16:0] max_abs_err_s;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  approx_adder_error_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .clear(clear),
    .stats_valid(stats_valid), .sample_count(sample_count), .err_count(err_count),
    .err_sum(err_sum), .sq_err_sum(sq_err_sum), .max_abs_err(max_abs_err));

  approx_adder_error_monitor #(.WIDTH(16), .CNT_W(4), .ESUM_W(8), .SQ_W(56)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .clear(clear),
    .stats_valid(stats_valid_s), .sample_count(sample_count_s), .err_count(err_count_s),
    .err_sum(err_sum_s), .sq_err_sum(sq_err_sum_s), .max_abs_err(max_abs_err_s));

  // model state per instance: 0 = default params, 1 = narrow counters
  longint m_cnt[2], m_ec[2], m_es[2], m_sq[2], m_max[2];
  longint lim_cnt[2], lim_es_hi[2], lim_es_lo[2], lim_sq[2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear(int k);
    m_cnt[k] = 0; m_ec[k] = 0; m_es[k] = 0; m_sq[k] = 0; m_max[k] = 0;
  endtask

  task automatic model_add(int k, logic [15:0] a, logic [15:0] b, logic [16:0] ap);
    longint e, ae;
    e  = longint'(ap) - (longint'(a) + longint'(b));
    ae = (e < 0) ? -e : e;
    m_cnt[k] = clamp(m_cnt[k] + 1, 0, lim_cnt[k]);
    if (e != 0) m_ec[k] = clamp(m_ec[k] + 1, 0, lim_cnt[k]);
    m_es[k] = clamp(m_es[k] + e, lim_es_lo[k], lim_es_hi[k]);
    m_sq[k] = clamp(m_sq[k] + ae * ae, 0, lim_sq[k]);
    if (ae > m_max[k]) m_max[k] = ae;
  endtask

  // called at a negedge; returns at the following negedge
  task automatic send(int k, logic [15:0] a, logic [15:0] b, logic [16:0] ap);
    in_a = a; in_b = b; in_approx = ap;
    if (k == 0) in_valid = 1'b1; else in_valid_s = 1'b1;
    if ((k == 0) ? in_ready : in_ready_s) model_add(k, a, b, ap);
    @(negedge clk);
    in_valid = 1'b0; in_valid_s = 1'b0;
  endtask

  task automatic wait_stats(int k, output int cyc);
    cyc = 0;
    while (!((k == 0) ? stats_valid : stats_valid_s) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_stats(int k, string tag);
    int cyc;
    wait_stats(k, cyc);
    if (k == 0) begin
      chk({tag, "_sv"},   64'(stats_valid), 64'd1);
      chk({tag, "_cnt"},  64'(sample_count), m_cnt[0]);
      chk({tag, "_ec"},   64'(err_count), m_ec[0]);
      chk({tag, "_es"},   64'(longint'($signed(err_sum))), m_es[0]);
      chk({tag, "_sq"},   64'(sq_err_sum), m_sq[0]);
      chk({tag, "_max"},  64'(max_abs_err), m_max[0]);
    end else begin
      chk({tag, "_sv"},   64'(stats_valid_s), 64'd1);
      chk({tag, "_cnt"},  64'(sample_count_s), m_cnt[1]);
      chk({tag, "_ec"},   64'(err_count_s), m_ec[1]);
      chk({tag, "_es"},   64'(longint'($signed(err_sum_s))), m_es[1]);
      chk({tag, "_sq"},   64'(sq_err_sum_s), m_sq[1]);
      chk({tag, "_max"},  64'(max_abs_err_s), m_max[1]);
    end
  endtask

  initial begin
    int cyc, low, drops, off;
    logic [15:0] a, b;
    logic [16:0] ap;

    lim_cnt[0] = (longint'(1) << 32) - 1; lim_cnt[1] = 15;
    lim_es_hi[0] = (longint'(1) << 39) - 1; lim_es_lo[0] = -(longint'(1) << 39);
    lim_es_hi[1] = 127; lim_es_lo[1] = -128;
    lim_sq[0] = (longint'(1) << 56) - 1; lim_sq[1] = lim_sq[0];
    model_clear(0); model_clear(1);

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_high", 64'(in_ready), 64'd1);
    check_stats(0, "reset");

    // exact and approximate samples
    send(0, 16'd0, 16'd0, 17'd0);
    send(0, 16'd3, 16'd5, 17'd10);
    send(0, 16'd5, 16'd3, 17'd0);
    wait_stats(0, cyc);
    chk("basic_latency", 64'(cyc), 64'd2);
    check_stats(0, "basic");
    chk("basic_es_const", 64'(longint'($signed(err_sum))), 64'(-6));
    chk("basic_sq_const", 64'(sq_err_sum), 64'd68);

    // full-range sums
    send(0, 16'hFFFF, 16'hFFFF, 17'h1FFFE);
    check_stats(0, "full_exact");
    send(0, 16'hFFFF, 16'hFFFF, 17'h00000);
    check_stats(0, "full_zero");
    chk("full_max_const", 64'(max_abs_err), 64'h1FFFE);

    // clear with two samples in flight
    send(0, 16'd10, 16'd20, 17'd40);
    clear = 1'b1;
    send(0, 16'd1, 16'd1, 17'd9);
    clear = 1'b0;
    model_clear(0);
    low = 0;
    while (!in_ready && low < 20) begin
      @(negedge clk);
      low++;
    end
    chk("clear_low_le3", 64'(low >= 1 && low <= 3), 64'd1);
    check_stats(0, "after_clear");
    send(0, 16'd7, 16'd7, 17'd11);
    check_stats(0, "post_clear");

    // throughput: 100 back-to-back samples, error +1
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    model_clear(0);
    while (!in_ready) @(negedge clk);
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom); b = 16'($urandom_range(0, 65534 - int'(a) > 0 ? 65534 - int'(a) : 0));
      if (!in_ready) drops++;
      send(0, a, b, 17'(int'(a) + int'(b) + 1));
    end
    chk("tput_drops", 64'(drops), 64'd0);
    check_stats(0, "tput");

    // random mix with idle gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      else begin
        a = 16'($urandom); b = 16'($urandom);
        case ($urandom_range(0, 2))
          0: ap = 17'(int'(a) + int'(b));
          1: begin off = int'($urandom_range(0, 64)) - 32; ap = 17'(int'(a) + int'(b) + off); end
          default: ap = 17'($urandom);
        endcase
        send(0, a, b, ap);
      end
    end
    check_stats(0, "random");

    // reset with S1 and S2 full
    send(0, 16'd100, 16'd100, 17'd300);
    send(0, 16'd50, 16'd50, 17'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear(0); model_clear(1);
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_sv", 64'(stats_valid), 64'd1);
    check_stats(0, "midrst");
    repeat (4) @(negedge clk);
    check_stats(0, "midrst_later");

    // saturation on the narrow instance
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom_range(0, 30000)); b = 16'($urandom_range(0, 30000));
      send(1, a, b, 17'(int'(a) + int'(b) + 20));
    end
    check_stats(1, "sat_pos");
    chk("sat_cnt_const", 64'(sample_count_s), 64'd15);
    chk("sat_es_const", 64'(err_sum_s), 64'd127);
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom_range(100, 30000)); b = 16'($urandom_range(0, 30000));
      send(1, a, b, 17'(int'(a) + int'(b) - 20));
    end
    check_stats(1, "sat_neg");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
